// File: rtl/tl_pkg.sv
// tl_pkg: shared types for the transaction-layer request path.
// Command bundle, kind enum, header FSM states, Fmt/Type codes, field offsets.
package tl_pkg;

    typedef enum logic {
        K_MEM = 1'b0,
        K_CFG = 1'b1
    } tl_req_kind_e;

    typedef struct packed {
        tl_req_kind_e kind;
        logic         wr_en;
        logic [63:0]  addr;
        logic [10:0]  len_dw;
        logic [3:0]   first_be;
        logic [3:0]   last_be;
        logic [7:0]   bus;
        logic [4:0]   device;
        logic [2:0]   function_num;
        logic [9:0]   reg_num;
    } tl_req_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAG,
        S_CRED,
        S_SEND
    } tl_hdr_state_e;

    localparam logic [7:0] FT_MRD32  = 8'h00;
    localparam logic [7:0] FT_MRD64  = 8'h20;
    localparam logic [7:0] FT_MWR32  = 8'h40;
    localparam logic [7:0] FT_MWR64  = 8'h60;
    localparam logic [7:0] FT_CFGRD0 = 8'h04;
    localparam logic [7:0] FT_CFGWR0 = 8'h44;

    localparam int HDR_FT_LSB  = 120;
    localparam int HDR_LEN_LSB = 96;
    localparam int HDR_RID_LSB = 80;
    localparam int HDR_TAG_LSB = 72;
    localparam int HDR_LBE_LSB = 68;
    localparam int HDR_FBE_LSB = 64;

    function automatic logic [7:0] mem_fmt_type(input logic wr,
                                                input logic is64);
        logic [7:0] ft;
        unique case ({wr, is64})
            2'b00:   ft = FT_MRD32;
            2'b01:   ft = FT_MRD64;
            2'b10:   ft = FT_MWR32;
            default: ft = FT_MWR64;
        endcase
        return ft;
    endfunction

endpackage

// File: rtl/tl_rr_arb.sv
// tl_rr_arb: combinational round-robin arbiter.
// Ports: req vector, ptr (last grant) in; one-hot grant, index, valid out.
module tl_rr_arb #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    logic [W-1:0] cand;

    // Scan ptr+1 .. ptr+N (circular); the first requester found wins.
    always_comb begin
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_oh[gnt_idx] = gnt_valid;
    end

endmodule

// File: rtl/tl_req_hdr_gen.sv
// tl_req_hdr_gen: arbitrates command channels, segments MEM requests and
// emits 3DW/4DW request headers gated by tags and posted/non-posted credits.
// Ports: cmd_i/cmd_valid_i/cmd_ready_o per channel; tag_i/tag_valid_i/
// tag_consume_o; credit_p_ok_i/credit_np_ok_i; hdr_* valid/ready; err_o.
module tl_req_hdr_gen
    import tl_pkg::*;
#(
    parameter  int          N_CH               = 4,
    parameter  int          TAG_W              = 8,
    parameter  int          MAX_PAYLOAD_BYTES  = 256,
    parameter  int          MAX_READ_REQ_BYTES = 512,
    parameter  logic [15:0] REQUESTER_ID       = 16'h1234,
    localparam int          CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  tl_req_cmd_t [N_CH-1:0] cmd_i,
    input  logic [N_CH-1:0]        cmd_valid_i,
    output logic [N_CH-1:0]        cmd_ready_o,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic                   tag_valid_i,
    output logic                   tag_consume_o,
    input  logic                   credit_p_ok_i,
    input  logic                   credit_np_ok_i,
    output logic [127:0]           hdr_o,
    output logic                   hdr_4dw_o,
    output logic [CH_W-1:0]        hdr_ch_o,
    output logic                   hdr_last_o,
    output logic                   is_posted_o,
    output logic                   hdr_valid_o,
    input  logic                   hdr_ready_i,
    output logic                   err_o
);

    localparam logic [10:0] MPS_DW  = 11'(MAX_PAYLOAD_BYTES / 4);
    localparam logic [10:0] MRRS_DW = 11'(MAX_READ_REQ_BYTES / 4);

    tl_hdr_state_e state_q, state_d;

    logic [N_CH-1:0]  gnt_oh;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_valid;
    logic             hs;
    tl_req_cmd_t      sel;

    logic [CH_W-1:0]  rr_ptr_q;
    logic [CH_W-1:0]  ch_q;
    tl_req_kind_e     kind_q;
    logic             wr_q;
    logic [63:0]      addr_q;
    logic [10:0]      rem_q;
    logic [3:0]       first_be_q;
    logic [3:0]       last_be_q;
    logic [7:0]       bus_q;
    logic [4:0]       dev_q;
    logic [2:0]       fn_q;
    logic [9:0]       reg_q;
    logic             first_seg_q;
    logic [TAG_W-1:0] tag_q;
    logic [10:0]      seg_len_q;

    logic [127:0]     hdr_q;
    logic             hdr_4dw_q;
    logic             hdr_last_q;
    logic             posted_q;
    logic             err_q;

    logic             posted;
    logic             is_cfg;
    logic             cred_ok;
    logic [10:0]      seg_lim;
    logic [10:0]      seg_len;
    logic             final_seg;
    logic             is64;
    logic [7:0]       ft;
    logic [9:0]       len10;
    logic [3:0]       fbe;
    logic [3:0]       lbe;
    logic [7:0]       tag8;
    logic [63:0]      lo64;
    logic [127:0]     hdr_d;

    tl_rr_arb #(
        .N (N_CH)
    ) u_arb (
        .req       (cmd_valid_i),
        .ptr       (rr_ptr_q),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign sel = cmd_i[gnt_idx];

    // Grants are only exposed while idle and out of reset.
    assign hs          = (state_q == S_IDLE) && !rst && gnt_valid;
    assign cmd_ready_o = ((state_q == S_IDLE) && !rst) ? gnt_oh : '0;

    assign tag_consume_o = (state_q == S_TAG) && tag_valid_i;
    assign hdr_valid_o   = (state_q == S_SEND);
    assign hdr_o         = hdr_q;
    assign hdr_4dw_o     = hdr_4dw_q;
    assign hdr_ch_o      = ch_q;
    assign hdr_last_o    = hdr_last_q;
    assign is_posted_o   = posted_q;
    assign err_o         = err_q;

    // Header for the segment starting at addr_q with rem_q DWs left.
    always_comb begin
        is_cfg    = (kind_q == K_CFG);
        posted    = !is_cfg && wr_q;
        cred_ok   = posted ? credit_p_ok_i : credit_np_ok_i;
        seg_lim   = posted ? MPS_DW : MRRS_DW;
        seg_len   = (rem_q < seg_lim) ? rem_q : seg_lim;
        final_seg = (rem_q == seg_len);
        is64      = 1'b0;
        ft        = 8'h00;
        len10     = 10'd0;
        fbe       = 4'h0;
        lbe       = 4'h0;
        lo64      = '0;
        tag8      = posted ? 8'h00 : 8'(tag_q);
        if (is_cfg) begin
            ft    = wr_q ? FT_CFGWR0 : FT_CFGRD0;
            len10 = 10'd1;
            fbe   = first_be_q;
            lbe   = 4'h0;
            lo64  = {bus_q, dev_q, fn_q, 4'h0, reg_q, 2'b00, 32'h0};
        end else begin
            is64  = (addr_q[63:32] != 32'h0);
            ft    = mem_fmt_type(wr_q, is64);
            // 1024 DW wraps to 0 in the 10-bit Length field.
            len10 = seg_len[9:0];
            fbe   = first_seg_q ? first_be_q : 4'hF;
            if (seg_len == 11'd1)
                lbe = 4'h0;
            else
                lbe = final_seg ? last_be_q : 4'hF;
            if (is64)
                lo64 = {addr_q[63:32], addr_q[31:2], 2'b00};
            else
                lo64 = {addr_q[31:2], 34'h0};
        end
        hdr_d = {ft, 14'h0, len10, REQUESTER_ID, tag8, lbe, fbe, lo64};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs && sel.len_dw != 11'd0) begin
                    if (sel.kind == K_MEM && sel.wr_en)
                        state_d = S_CRED;
                    else
                        state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (tag_valid_i)
                    state_d = S_CRED;
            end
            S_CRED: begin
                if (cred_ok)
                    state_d = S_SEND;
            end
            S_SEND: begin
                if (hdr_ready_i) begin
                    if (rem_q != 11'd0)
                        state_d = posted ? S_CRED : S_TAG;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= CH_W'(N_CH - 1);
            ch_q        <= '0;
            kind_q      <= K_MEM;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            first_be_q  <= '0;
            last_be_q   <= '0;
            bus_q       <= '0;
            dev_q       <= '0;
            fn_q        <= '0;
            reg_q       <= '0;
            first_seg_q <= 1'b0;
            tag_q       <= '0;
            seg_len_q   <= '0;
            hdr_q       <= '0;
            hdr_4dw_q   <= 1'b0;
            hdr_last_q  <= 1'b0;
            posted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= hs && (sel.len_dw == 11'd0);
            if (hs) begin
                rr_ptr_q    <= gnt_idx;
                ch_q        <= gnt_idx;
                kind_q      <= sel.kind;
                wr_q        <= sel.wr_en;
                addr_q      <= sel.addr;
                rem_q       <= sel.len_dw;
                first_be_q  <= sel.first_be;
                last_be_q   <= sel.last_be;
                bus_q       <= sel.bus;
                dev_q       <= sel.device;
                fn_q        <= sel.function_num;
                reg_q       <= sel.reg_num;
                first_seg_q <= 1'b1;
            end
            if (tag_consume_o)
                tag_q <= tag_i;
            if (state_q == S_CRED && cred_ok) begin
                hdr_q      <= hdr_d;
                hdr_4dw_q  <= is64;
                hdr_last_q <= is_cfg || final_seg;
                posted_q   <= posted;
                seg_len_q  <= seg_len;
                rem_q      <= is_cfg ? 11'd0 : rem_q - seg_len;
            end
            if (state_q == S_SEND && hdr_ready_i && rem_q != 11'd0) begin
                addr_q      <= addr_q + {51'h0, seg_len_q, 2'b00};
                first_seg_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tl_req_hdr_gen.sv
// tb_tl_req_hdr_gen: directed self-checking bench for tl_req_hdr_gen.
// Drives commands, tags and credits; checks headers against fixed values.
module tb_tl_req_hdr_gen;
    import tl_pkg::*;

    localparam int N_CH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    tl_req_cmd_t [N_CH-1:0] cmd;
    logic [N_CH-1:0]        cmd_valid;
    logic [N_CH-1:0]        cmd_ready;
    logic [7:0]             tag_i;
    logic                   tag_valid;
    logic                   tag_consume;
    logic                   cp_ok;
    logic                   cnp_ok;
    logic [127:0]           hdr;
    logic                   hdr_4dw;
    logic [1:0]             hdr_ch;
    logic                   hdr_last;
    logic                   is_posted;
    logic                   hdr_valid;
    logic                   hdr_ready;
    logic                   err;

    int         checks = 0;
    int         errors = 0;
    int         n_cons = 0;
    int         saved_cons;
    logic [7:0] last_tag = 8'h00;
    bit         seen;
    bit         stable;
    logic [127:0] exp_b [3];
    int         exp_c [5];

    always #5 clk = ~clk;

    tl_req_hdr_gen dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_i          (cmd),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .tag_i          (tag_i),
        .tag_valid_i    (tag_valid),
        .tag_consume_o  (tag_consume),
        .credit_p_ok_i  (cp_ok),
        .credit_np_ok_i (cnp_ok),
        .hdr_o          (hdr),
        .hdr_4dw_o      (hdr_4dw),
        .hdr_ch_o       (hdr_ch),
        .hdr_last_o     (hdr_last),
        .is_posted_o    (is_posted),
        .hdr_valid_o    (hdr_valid),
        .hdr_ready_i    (hdr_ready),
        .err_o          (err)
    );

    function automatic tl_req_cmd_t mk(input tl_req_kind_e k,
                                       input logic wr,
                                       input logic [63:0] a,
                                       input logic [10:0] len,
                                       input logic [3:0] fb,
                                       input logic [3:0] lb,
                                       input logic [7:0] b,
                                       input logic [4:0] d,
                                       input logic [2:0] f,
                                       input logic [9:0] r);
        tl_req_cmd_t c;
        c.kind         = k;
        c.wr_en        = wr;
        c.addr         = a;
        c.len_dw       = len;
        c.first_be     = fb;
        c.last_be      = lb;
        c.bus          = b;
        c.device       = d;
        c.function_num = f;
        c.reg_num      = r;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the tag source hands out tag_i and advances on consume.
    task automatic tick();
        logic c;
        #1;
        c = tag_consume;
        @(posedge clk);
        if (c === 1'b1) begin
            last_tag = tag_i;
            n_cons++;
        end
        #1;
        if (c === 1'b1)
            tag_i = tag_i + 8'd1;
    endtask

    task automatic wait_hdr(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (hdr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 128'(ok), 128'(1));
    endtask

    initial begin
        exp_b[0] = {32'h20000080, 16'h1234, 8'h05, 8'hFC, 32'h1, 32'h000};
        exp_b[1] = {32'h20000080, 16'h1234, 8'h06, 8'hFF, 32'h1, 32'h200};
        exp_b[2] = {32'h2000002C, 16'h1234, 8'h07, 8'h3F, 32'h1, 32'h400};
        exp_c[0] = 1;
        exp_c[1] = 2;
        exp_c[2] = 3;
        exp_c[3] = 0;
        exp_c[4] = 1;

        for (int i = 0; i < N_CH; i++)
            cmd[i] = mk(K_MEM, 1'b1, 64'h0, 11'd1, 4'hF, 4'hF,
                        8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = '1;
        tag_i     = 8'h00;
        tag_valid = 1'b0;
        cp_ok     = 1'b1;
        cnp_ok    = 1'b1;
        hdr_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 128'(cmd_ready), 128'(0));
        chk("rst_valid", 128'(hdr_valid), 128'(0));
        chk("rst_hdr", hdr, 128'h0);
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_cons", 128'(tag_consume), 128'(0));
        cmd_valid = '0;
        rst = 1'b0;
        tick();

        // A: single MWr32 on channel 1, exact latency
        cmd[1] = mk(K_MEM, 1'b1, 64'h1000, 11'd4, 4'hF, 4'hF,
                    8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = 4'b0010;
        #1;
        chk("A_ready", 128'(cmd_ready), 128'(4'b0010));
        tick();
        cmd_valid = '0;
        chk("A_t1_valid", 128'(hdr_valid), 128'(0));
        tick();
        chk("A_t2_valid", 128'(hdr_valid), 128'(1));
        chk("A_hdr", hdr, 128'h40000004_123400FF_00001000_00000000);
        chk("A_4dw", 128'(hdr_4dw), 128'(0));
        chk("A_last", 128'(hdr_last), 128'(1));
        chk("A_posted", 128'(is_posted), 128'(1));
        chk("A_ch", 128'(hdr_ch), 128'(1));
        tick();
        chk("A_done", 128'(hdr_valid), 128'(0));

        // B: MRd64 len 300 split 128/128/44 with tags 5,6,7
        tag_valid = 1'b1;
        tag_i     = 8'd5;
        n_cons    = 0;
        cmd[0] = mk(K_MEM, 1'b0, 64'h1_0000_0000, 11'd300, 4'hC, 4'h3,
                    8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = 4'b0001;
        #1;
        chk("B_ready", 128'(cmd_ready), 128'(4'b0001));
        tick();
        cmd_valid = '0;
        for (int s = 0; s < 3; s++) begin
            wait_hdr("B_wait", 10);
            chk("B_hdr", hdr, exp_b[s]);
            chk("B_4dw", 128'(hdr_4dw), 128'(1));
            chk("B_last", 128'(hdr_last), 128'(s == 2));
            chk("B_posted", 128'(is_posted), 128'(0));
            chk("B_ch", 128'(hdr_ch), 128'(0));
            tick();
        end
        chk("B_cons", 128'(n_cons), 128'(3));

        // C: all channels valid, round-robin from pointer 0
        for (int i = 0; i < N_CH; i++)
            cmd[i] = mk(K_MEM, 1'b1, 64'((i + 1) * 256), 11'd1, 4'hF,
                        4'hF, 8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_hdr("C_wait", 10);
            chk("C_ch", 128'(hdr_ch), 128'(exp_c[k]));
            chk("C_dw0", 128'(hdr[127:96]), 128'(32'h40000001));
            chk("C_rest", 128'(hdr[95:0]),
                128'({16'h1234, 8'h00, 8'h0F,
                      32'((exp_c[k] + 1) * 256), 32'h0}));
            tick();
        end
        cmd_valid = '0;

        // D: CfgWr0 held off by non-posted credit
        cnp_ok    = 1'b0;
        hdr_ready = 1'b0;
        cmd[2] = mk(K_CFG, 1'b1, 64'h0, 11'd1, 4'hF, 4'h0,
                    8'd3, 5'd2, 3'd1, 10'h3F);
        cmd_valid = 4'b0100;
        #1;
        chk("D_ready", 128'(cmd_ready), 128'(4'b0100));
        tick();
        cmd_valid = '0;
        seen = 1'b0;
        repeat (10) begin
            if (hdr_valid === 1'b1)
                seen = 1'b1;
            tick();
        end
        chk("D_stall", 128'(seen), 128'(0));
        cnp_ok = 1'b1;
        wait_hdr("D_wait", 5);
        chk("D_dw0", 128'(hdr[127:96]), 128'(32'h44000001));
        chk("D_dw2", 128'(hdr[63:32]), 128'(32'h031100FC));
        chk("D_dw1", 128'(hdr[95:64]), 128'({16'h1234, last_tag, 8'h0F}));
        chk("D_dw3", 128'(hdr[31:0]), 128'(0));
        chk("D_posted", 128'(is_posted), 128'(0));
        chk("D_last", 128'(hdr_last), 128'(1));
        chk("D_4dw", 128'(hdr_4dw), 128'(0));
        chk("D_ch", 128'(hdr_ch), 128'(2));

        // E: downstream stall, outputs must hold (credit drop ignored)
        cnp_ok = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (hdr_valid !== 1'b1 || hdr_ch !== 2'd2 ||
                hdr !== {32'h44000001, 16'h1234, last_tag, 8'h0F,
                         32'h031100FC, 32'h0})
                stable = 1'b0;
        end
        chk("E_stable", 128'(stable), 128'(1));
        hdr_ready = 1'b1;
        cnp_ok    = 1'b1;
        tick();
        chk("E_done", 128'(hdr_valid), 128'(0));

        // F: zero-length command dropped with one-cycle error pulse
        saved_cons = n_cons;
        cmd[3] = mk(K_MEM, 1'b0, 64'h2000, 11'd0, 4'hF, 4'hF,
                    8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = 4'b1000;
        #1;
        chk("F_ready", 128'(cmd_ready), 128'(4'b1000));
        tick();
        cmd_valid = '0;
        chk("F_err1", 128'(err), 128'(1));
        tick();
        chk("F_err0", 128'(err), 128'(0));
        seen = 1'b0;
        repeat (6) begin
            if (hdr_valid === 1'b1)
                seen = 1'b1;
            tick();
        end
        chk("F_nohdr", 128'(seen), 128'(0));
        chk("F_nocons", 128'(n_cons), 128'(saved_cons));

        // G: async reset while a header is held in S_SEND
        hdr_ready = 1'b0;
        cmd[0] = mk(K_MEM, 1'b1, 64'h3000, 11'd2, 4'hF, 4'hF,
                    8'h0, 5'h0, 3'h0, 10'h0);
        cmd_valid = 4'b0001;
        tick();
        cmd_valid = '0;
        wait_hdr("G_wait", 5);
        rst = 1'b1;
        #1;
        chk("G_valid", 128'(hdr_valid), 128'(0));
        chk("G_hdr", hdr, 128'h0);
        chk("G_posted", 128'(is_posted), 128'(0));
        chk("G_ch", 128'(hdr_ch), 128'(0));
        chk("G_last", 128'(hdr_last), 128'(0));
        tick();
        rst = 1'b0;
        hdr_ready = 1'b1;
        cmd_valid = 4'b0011;
        #1;
        chk("G_arb", 128'(cmd_ready), 128'(4'b0001));
        tick();
        cmd_valid = '0;
        wait_hdr("G_wait2", 5);
        chk("G_hdr2", hdr, 128'h40000002_123400FF_00003000_00000000);
        chk("G_ch2", 128'(hdr_ch), 128'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
